// File: rtl/cp0_vec.sv
// Coprocessor-0 with vectored multi-line interrupts, COUNT/COMPARE timer and held fetch redirect.
// Latency: data_r combinational; ir_in edge -> IP after 3 edges, ir one edge later; take/ERET -> jump_en after the edge.
// Backpressure: jump_en/jump_addr hold until jump_ack; no new take or ERET is accepted while a redirect is outstanding.
//
// Ports: clk/rst_n (async active-low), oper/addr_r/data_r/addr_w/data_w register access,
//        ir_in external lines, ret_addr/ret_valid MEM commit point, jump_ack/jump_en/jump_addr
//        redirect handshake, ir registered pending-interrupt flag.
module cp0_vec #(
    parameter int          NUM_IRQ    = 8,
    parameter int          VEC_SHIFT  = 4,
    parameter logic [31:0] EHBR_RESET = 32'h0000_0100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         oper,
    input  logic [4:0]         addr_r,
    output logic [31:0]        data_r,
    input  logic [4:0]         addr_w,
    input  logic [31:0]        data_w,
    input  logic [NUM_IRQ-1:0] ir_in,
    input  logic [31:0]        ret_addr,
    input  logic               ret_valid,
    input  logic               jump_ack,
    output logic               jump_en,
    output logic [31:0]        jump_addr,
    output logic               ir
);
    // External lines 0..NUM_IRQ-1 plus the timer line at index NUM_IRQ.
    localparam int NL = NUM_IRQ + 1;

    typedef enum logic [1:0] {IDLE, REQ_INT, REQ_RET} state_t;

    state_t state_q, state_d;

    logic [NUM_IRQ-1:0] sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [NL-1:0]      ip_q, ip_d, im_q, im_d;
    logic               ie_q, ie_d, exl_q, exl_d, ir_q, ir_d;
    logic [4:0]         code_q, code_d;
    logic [31:0]        count_q, count_d, compare_q, compare_d;
    logic [31:0]        epc_q, epc_d, ehbr_q, ehbr_d, jump_addr_q, jump_addr_d;

    logic               is_wr, is_eret, take, eret_go, timer_hit;
    logic [NL-1:0]      pend, take_oh, set_vec;
    logic [4:0]         take_id;
    logic [31:0]        count_inc, status_w, cause_w;

    assign is_wr   = (oper == 2'b10);
    assign is_eret = (oper == 2'b11);

    // Lowest pending unmasked line wins; one-hot copy avoids a variable-width index on ip.
    always_comb begin
        pend    = ip_q & im_q;
        take_id = '0;
        take_oh = '0;
        for (int i = NL - 1; i >= 0; i--) begin
            if (pend[i]) begin
                take_id    = 5'(i);
                take_oh    = '0;
                take_oh[i] = 1'b1;
            end
        end
        eret_go = is_eret && (state_q == IDLE);
        // ERET has priority over a take in the same cycle.
        take    = ie_q && !exl_q && (|pend) && ret_valid && (state_q == IDLE) && !is_eret;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (eret_go) begin
                    state_d = REQ_RET;
                end else if (take) begin
                    state_d = REQ_INT;
                end
            end
            REQ_INT, REQ_RET: begin
                if (jump_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        jump_en   = (state_q != IDLE);
        jump_addr = jump_addr_q;
        ir        = ir_q;
    end

    // Register datapath.
    always_comb begin
        sync1_d   = ir_in;
        sync2_d   = sync1_q;
        sync3_d   = sync2_q;

        count_inc = count_q + 32'd1;
        timer_hit = (count_inc == compare_q);
        set_vec   = {timer_hit, sync2_q & ~sync3_q};

        count_d   = (is_wr && addr_w == 5'd9)  ? data_w : count_inc;
        compare_d = (is_wr && addr_w == 5'd11) ? data_w : compare_q;
        ehbr_d    = (is_wr && addr_w == 5'd15) ? data_w : ehbr_q;
        epc_d     = (is_wr && addr_w == 5'd14) ? data_w : epc_q;
        code_d    = code_q;

        ie_d  = ie_q;
        exl_d = exl_q;
        im_d  = im_q;
        if (is_wr && addr_w == 5'd12) begin
            ie_d  = data_w[0];
            exl_d = data_w[1];
            im_d  = data_w[8+NUM_IRQ:8];
        end

        ip_d = ip_q;
        if (is_wr && addr_w == 5'd13) begin
            ip_d = ip_d & ~data_w[8+NUM_IRQ:8];
        end
        if (is_wr && addr_w == 5'd11) begin
            ip_d[NUM_IRQ] = 1'b0;
        end
        if (take) begin
            ip_d   = ip_d & ~take_oh;
            exl_d  = 1'b1;
            epc_d  = ret_addr;
            code_d = take_id;
        end
        if (eret_go) begin
            exl_d = 1'b0;
        end
        // New events are ORed in last so a same-cycle set beats any clear.
        ip_d = ip_d | set_vec;

        ir_d = ie_q && !exl_q && (|pend);

        jump_addr_d = jump_addr_q;
        if (state_q == IDLE) begin
            if (eret_go) begin
                jump_addr_d = epc_q;
            end else if (take) begin
                jump_addr_d = ehbr_q + (32'(take_id) << VEC_SHIFT);
            end
        end else if (jump_ack) begin
            jump_addr_d = '0;
        end
    end

    // Read mux.
    always_comb begin
        status_w                 = '0;
        status_w[0]              = ie_q;
        status_w[1]              = exl_q;
        status_w[8+NUM_IRQ:8]    = im_q;
        cause_w                  = '0;
        cause_w[8+NUM_IRQ:8]     = ip_q;
        cause_w[6:2]             = code_q;
        case (addr_r)
            5'd9:    data_r = count_q;
            5'd11:   data_r = compare_q;
            5'd12:   data_r = status_w;
            5'd13:   data_r = cause_w;
            5'd14:   data_r = epc_q;
            5'd15:   data_r = ehbr_q;
            default: data_r = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync3_q     <= '0;
            ip_q        <= '0;
            im_q        <= '0;
            ie_q        <= 1'b0;
            exl_q       <= 1'b0;
            ir_q        <= 1'b0;
            code_q      <= '0;
            count_q     <= '0;
            compare_q   <= 32'hFFFF_FFFF;
            epc_q       <= '0;
            ehbr_q      <= EHBR_RESET;
            jump_addr_q <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            ip_q        <= ip_d;
            im_q        <= im_d;
            ie_q        <= ie_d;
            exl_q       <= exl_d;
            ir_q        <= ir_d;
            code_q      <= code_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            epc_q       <= epc_d;
            ehbr_q      <= ehbr_d;
            jump_addr_q <= jump_addr_d;
        end
    end
endmodule

// File: tb/tb_cp0_vec.sv
module tb_cp0_vec;
    localparam int NI = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    oper = '0;
    logic [4:0]    addr_r = '0;
    logic [31:0]   data_r;
    logic [4:0]    addr_w = '0;
    logic [31:0]   data_w = '0;
    logic [NI-1:0] ir_in = '0;
    logic [31:0]   ret_addr = '0;
    logic          ret_valid = 1'b0;
    logic          jump_ack = 1'b0;
    logic          jump_en;
    logic [31:0]   jump_addr;
    logic          ir;

    always #5 clk = ~clk;

    cp0_vec dut (
        .clk(clk), .rst_n(rst_n), .oper(oper), .addr_r(addr_r), .data_r(data_r),
        .addr_w(addr_w), .data_w(data_w), .ir_in(ir_in), .ret_addr(ret_addr),
        .ret_valid(ret_valid), .jump_ack(jump_ack), .jump_en(jump_en),
        .jump_addr(jump_addr), .ir(ir)
    );

    int checks = 0;
    int failures = 0;

    // Architectural model state.
    logic [31:0]   m_count, m_compare, m_epc, m_ehbr, m_jaddr;
    logic          m_ie, m_exl, m_jen, m_ir;
    logic [NI:0]   m_im, m_ip;
    logic [4:0]    m_code;
    logic [NI-1:0] h1, h2, h3;   // ir_in as sampled at the last three edges

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_count = 0; m_compare = 32'hFFFF_FFFF; m_epc = 0; m_ehbr = 32'h100; m_jaddr = 0;
        m_ie = 0; m_exl = 0; m_jen = 0; m_ir = 0; m_im = 0; m_ip = 0; m_code = 0;
        h1 = 0; h2 = 0; h3 = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            5'd9:  r = m_count;
            5'd11: r = m_compare;
            5'd12: begin r[0] = m_ie; r[1] = m_exl; r[NI+8:8] = m_im; end
            5'd13: begin r[NI+8:8] = m_ip; r[6:2] = m_code; end
            5'd14: r = m_epc;
            5'd15: r = m_ehbr;
            default: r = '0;
        endcase
        return r;
    endfunction

    // One clock: evaluate the rules on the current inputs, clock, commit, compare every output.
    task automatic step();
        logic [NI:0] pend, n_ip, n_im;
        logic [31:0] n_count, n_compare, n_epc, n_ehbr, n_jaddr;
        logic        n_ie, n_exl, n_jen, n_ir, take, eret, wr;
        logic [4:0]  n_code;
        int          id;
        pend = m_ip & m_im;
        id = -1;
        for (int i = 0; i <= NI; i++) if (pend[i] && id < 0) id = i;
        wr   = (oper == 2'd2);
        eret = (oper == 2'd3) && !m_jen;
        take = m_ie && !m_exl && (pend != 0) && ret_valid && !m_jen && (oper != 2'd3);

        n_count   = (wr && addr_w == 9)  ? data_w : m_count + 1;
        n_compare = (wr && addr_w == 11) ? data_w : m_compare;
        n_ehbr    = (wr && addr_w == 15) ? data_w : m_ehbr;
        n_epc     = (wr && addr_w == 14) ? data_w : m_epc;
        n_ie = m_ie; n_exl = m_exl; n_im = m_im; n_code = m_code;
        if (wr && addr_w == 12) begin n_ie = data_w[0]; n_exl = data_w[1]; n_im = data_w[NI+8:8]; end
        n_ip = m_ip;
        if (wr && addr_w == 13) n_ip = n_ip & ~data_w[NI+8:8];
        if (wr && addr_w == 11) n_ip[NI] = 1'b0;
        if (take) begin n_ip[id] = 1'b0; n_exl = 1; n_epc = ret_addr; n_code = 5'(id); end
        if (eret) n_exl = 0;
        n_ip = n_ip | {(m_count + 32'd1) == m_compare, h2 & ~h3};
        n_ir = m_ie && !m_exl && (pend != 0);
        n_jen = m_jen; n_jaddr = m_jaddr;
        if (m_jen) begin
            if (jump_ack) begin n_jen = 0; n_jaddr = 0; end
        end else if (eret) begin
            n_jen = 1; n_jaddr = m_epc;
        end else if (take) begin
            n_jen = 1; n_jaddr = m_ehbr + 32'(id * 16);
        end

        @(posedge clk);
        #1;
        h3 = h2; h2 = h1; h1 = ir_in;
        m_count = n_count; m_compare = n_compare; m_ehbr = n_ehbr; m_epc = n_epc;
        m_ie = n_ie; m_exl = n_exl; m_im = n_im; m_code = n_code; m_ip = n_ip;
        m_ir = n_ir; m_jen = n_jen; m_jaddr = n_jaddr;

        check("jump_en", 32'(jump_en), 32'(m_jen));
        check("jump_addr", jump_addr, m_jaddr);
        check("ir", 32'(ir), 32'(m_ir));
        check("data_r", data_r, m_read(addr_r));
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        oper = 2'd2; addr_w = a; data_w = d;
        step();
        oper = 2'd0;
    endtask

    task automatic rd_check(input string name, input logic [4:0] a, input logic [31:0] exp);
        addr_r = a;
        #1;
        check(name, data_r, exp);
    endtask

    task automatic wait_jen(input string name, input int maxc, output int n);
        n = 0;
        while (jump_en !== 1'b1 && n < maxc) begin
            step();
            n++;
        end
        check({name, "_jump_seen"}, 32'(jump_en), 32'd1);
    endtask

    task automatic ack();
        jump_ack = 1'b1;
        step();
        jump_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        m_reset();
        #12 rst_n = 1'b1;

        // Reset state.
        check("rst_jump_en", 32'(jump_en), 32'd0);
        check("rst_jump_addr", jump_addr, 32'd0);
        check("rst_ir", 32'(ir), 32'd0);
        rd_check("rst_ehbr", 5'd15, 32'h0000_0100);
        rd_check("rst_compare", 5'd11, 32'hFFFF_FFFF);
        addr_r = 5'd9;
        for (int i = 0; i < 5; i++) step();
        rd_check("count_after_5", 5'd9, 32'd5);

        // Single line 3 take, redirect held for 3 cycles.
        wr_reg(5'd12, 32'h0001_FF01);
        ret_valid = 1'b1; ret_addr = 32'h400;
        ir_in = 8'h08;
        step();
        ir_in = 8'h00;
        wait_jen("line3", 10, n);
        check("line3_latency", 32'(n + 1), 32'd4);
        check("line3_addr", jump_addr, 32'h130);
        step();
        check("line3_hold1", 32'(jump_en), 32'd1);
        step();
        check("line3_hold2", 32'(jump_en), 32'd1);
        ack();
        check("line3_acked", 32'(jump_en), 32'd0);
        rd_check("line3_epc", 5'd14, 32'h400);
        rd_check("line3_cause", 5'd13, 32'h0000_000C);
        rd_check("line3_status", 5'd12, 32'h0001_FF03);

        // Lines 5 and 2 together: 2 first, ERET, then 5.
        wr_reg(5'd12, 32'h0001_FF01);
        ret_addr = 32'h500;
        ir_in = 8'h24;
        step();
        ir_in = 8'h00;
        wait_jen("line2", 10, n);
        check("line2_addr", jump_addr, 32'h120);
        ack();
        rd_check("line2_cause", 5'd13, 32'h0000_2008);
        oper = 2'd3;
        step();
        oper = 2'd0;
        check("eret_addr", jump_addr, 32'h500);
        ack();
        wait_jen("line5", 5, n);
        check("line5_addr", jump_addr, 32'h150);
        ack();

        // Masked line 1 stays pending, then W1C.
        wr_reg(5'd12, 32'h0001_FD01);
        ir_in = 8'h02;
        step();
        ir_in = 8'h00;
        for (int i = 0; i < 6; i++) step();
        rd_check("mask_cause", 5'd13, 32'h0000_0214);
        check("mask_ir", 32'(ir), 32'd0);
        check("mask_no_jump", 32'(jump_en), 32'd0);
        wr_reg(5'd13, 32'h0000_0200);
        rd_check("w1c_cause", 5'd13, 32'h0000_0014);

        // Timer interrupt.
        wr_reg(5'd12, 32'h0001_FF01);
        wr_reg(5'd9, 32'd0);
        wr_reg(5'd11, 32'd20);
        wait_jen("timer", 40, n);
        check("timer_addr", jump_addr, 32'h180);
        rd_check("timer_cause", 5'd13, 32'h0000_0020);
        ack();
        wr_reg(5'd9, 32'd0);
        wr_reg(5'd11, 32'd10);
        for (int i = 0; i < 12; i++) step();
        rd_check("timer_pending", 5'd13, 32'h0001_0020);
        wr_reg(5'd11, 32'hFFFF_FFFF);
        rd_check("compare_clr", 5'd13, 32'h0000_0020);

        // ERET and eligible interrupt in the same cycle, then reset mid-request.
        wr_reg(5'd14, 32'h600);
        ir_in = 8'h10;
        step();
        ir_in = 8'h00;
        for (int i = 0; i < 4; i++) step();
        wr_reg(5'd12, 32'h0001_FF01);
        oper = 2'd3;
        step();
        oper = 2'd0;
        check("race_eret_addr", jump_addr, 32'h600);
        ack();
        wait_jen("line4", 5, n);
        check("line4_addr", jump_addr, 32'h140);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_jump_en", 32'(jump_en), 32'd0);
        check("async_rst_jump_addr", jump_addr, 32'd0);
        m_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        rd_check("rst_cause", 5'd13, 32'd0);
        rd_check("rst_status", 5'd12, 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 9);
            oper = (r <= 5) ? 2'd0 : (r == 6) ? 2'd1 : (r <= 8) ? 2'd2 : 2'd3;
            addr_r = 5'($urandom_range(0, 31));
            r = $urandom_range(0, 4);
            case (r)
                0: begin addr_w = 5'd11; data_w = m_count + 32'($urandom_range(3, 40)); end
                1: begin
                    addr_w = 5'd12;
                    data_w = {15'b0, 9'($urandom), 6'b0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)};
                end
                2: begin addr_w = 5'd13; data_w = $urandom; end
                3: begin addr_w = 5'd14; data_w = $urandom; end
                default: begin addr_w = 5'd15; data_w = $urandom; end
            endcase
            if ($urandom_range(0, 3) == 0) ir_in = ir_in ^ (8'd1 << $urandom_range(0, NI - 1));
            ret_valid = ($urandom_range(0, 3) != 0);
            ret_addr = $urandom;
            jump_ack = ($urandom_range(0, 2) == 0);
            if (c == 1500) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                check("rand_rst_jump_en", 32'(jump_en), 32'd0);
                m_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cp0_vec.md
# cp0_vec

Parametrised coprocessor-0 with a multi-line vectored interrupt controller, an internal timer interrupt, and a held jump handshake toward the fetch stage.
- Register reads are combinational in ID; writes and ERET commit in EXE; interrupts are taken on `ret_addr` at the MEM commit point.
- Extends the single-line, level-edge CP0:
  - per-line edge capture, masking and fixed priority,
  - vectored handler addresses,
  - COUNT/COMPARE timer,
  - write-1-to-clear pending bits,
  - a jump request held until fetch accepts it.

## Interface
- NUM_IRQ, 8: external interrupt lines, 1..15. Line index NUM_IRQ is the internal timer line.
- VEC_SHIFT, 4: handler vector spacing, 2^VEC_SHIFT bytes per line.
- EHBR_RESET, 32'h0000_0100: reset value of EHBR.
- clk  in  1  main clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- oper  in  2  00 none, 01 MFC0 (read only), 10 MTC0 write, 11 ERET.
- addr_r  in  5  read register address.
- data_r  out  32  combinational read data. Unmapped addresses read 0.
- addr_w  in  5  write register address.
- data_w  in  32  write data.
- ir_in  in  NUM_IRQ  asynchronous external interrupt lines, rising-edge significant.
- ret_addr  in  32  EPC value to save when an interrupt is taken.
- ret_valid  in  1  MEM holds a committable instruction. An interrupt is taken only when this is 1.
- jump_ack  in  1  fetch accepted the redirect.
- jump_en  out  1  redirect request, held until acknowledged.
- jump_addr  out  32  redirect target.
- ir  out  1  registered; 1 when an unmasked, enabled interrupt is pending and not blocked by EXL.

## Operation
- Register map:
  - 9 COUNT.
  - 11 COMPARE.
  - 12 STATUS: bit0 IE, bit1 EXL, bits[8+NUM_IRQ:8] IM.
  - 13 CAUSE: bits[8+NUM_IRQ:8] IP read-only/W1C, bits[6:2] code = taken line id.
  - 14 EPC.
  - 15 EHBR.
- Synchronisation and edge capture: each ir_in bit passes through 2 flops. A 0→1 transition at the synchroniser output sets IP[i] on the next edge.
- Timer line:
  - COUNT increments every cycle and wraps at 2^32.
  - When the incremented COUNT equals COMPARE, IP[NUM_IRQ] is set.
  - MTC0 to COMPARE clears IP[NUM_IRQ].
  - MTC0 to COUNT replaces that cycle's increment.
- Pending-bit clears: MTC0 to CAUSE clears each IP bit where data_w is 1. A set and a clear of the same bit in the same cycle leaves the bit set.
- Take condition: IE & !EXL & |(IP & IM) & ret_valid & state IDLE & oper != ERET. Line selection is lowest index first.
- FSM states: IDLE, REQ_INT, REQ_RET.
  - IDLE→REQ_INT on take. On that edge:
    - EPC←ret_addr,
    - EXL←1,
    - code←id,
    - IP[id]←0, unless a new edge on id arrives in the same cycle,
    - jump_addr←EHBR + (id << VEC_SHIFT) (32-bit wrap),
    - jump_en←1.
  - IDLE→REQ_RET on oper=ERET. On that edge: EXL←0, jump_addr←EPC, jump_en←1.
  - REQ_INT/REQ_RET→IDLE on jump_ack=1. jump_en←0 and jump_addr←0 on that edge.
  - ERET received in REQ_INT or REQ_RET is ignored: the pipeline is flushing.
- Simultaneous events:
  - ERET and an interrupt in the same cycle: ERET wins. The interrupt is re-evaluated the following cycle with EXL=0.
  - MTC0 to STATUS in the take cycle: the written value lands, then EXL is forced to 1.
  - MTC0 to EPC in the take cycle: the take's ret_addr wins.
- Reset values:
  - STATUS=0, CAUSE=0, EPC=0, EHBR=EHBR_RESET, COUNT=0, COMPARE=32'hFFFF_FFFF.
  - Synchronisers=0, state IDLE.
  - jump_en=0, jump_addr=0, ir=0.

## Timing
- data_r: zero-cycle combinational from addr_r and the current register state. A write becomes visible the cycle after its edge.
- ir_in edge → IP set: 3 clk edges (2 synchroniser edges + 1 capture edge). ir follows IP one edge later.
- Take edge → jump_en=1 after the same edge. jump_en stays high until the jump_ack edge, even for multiple cycles.
- Reset mid-request: async deassertion of jump_en and clearing of all state. No pending IP survives.
- A new take is impossible while EXL=1. Nested interrupts require software to clear EXL via STATUS write.

## Test plan
- Post-reset: all outputs 0. Read addr 15 = 32'h100, read addr 11 = 32'hFFFFFFFF. COUNT reads 5 after 5 cycles.
- IE=1, IM=8'hFF, pulse ir_in[3] with ret_valid=1 and ret_addr=32'h400:
  - jump_en rises 4 edges later with jump_addr=32'h130, EPC=32'h400, code=3, IP[3]=0.
  - jump_en holds 3 cycles until jump_ack.
- Raise ir_in[5] and ir_in[2] together: line 2 is taken (jump_addr 32'h120), IP[5] stays set. ERET → jump to EPC. The following take is line 5 (32'h150).
- IM masks line 1 and ir_in[1] pulses: IP[1]=1, ir=0, no jump. Write CAUSE data_w bit9=1 → IP[1]=0.
- COMPARE=20, IE=1, IM bit NUM_IRQ set: timer take with code=8 and jump_addr=32'h180. Write COMPARE → IP[8]=0.
- ERET and an eligible interrupt in the same cycle: ERET redirect to EPC first. Interrupt redirect after ack. Assert rst_n=0 mid-REQ_INT → jump_en=0 immediately.
